axi4_lite_i2c_init_seq: RTL and testbench
=========================================

// Module: axi4_lite_i2c_init_seq
// PURPOSE
//  Boot-time sequencer driving axi4_lite_i2c_master_bridge as its sole AXI4-Lite master.
//  Walks a command table (external sync ROM/RAM), issues one register write per entry, inserts programmed delays,
//  retries writes answered with SLVERR, reports done/error with failing entry index. Sits between sensor/codec init ROM and the bridge.
// PARAMETERS
//  DATA_WIDTH        8         register data width, multiple of 8, matches bridge
//  ADDR_WIDTH        8         register address width, multiple of 8, matches bridge
//  TBL_DEPTH         256       table entries; TBL_AW = $clog2(TBL_DEPTH)
//  MAX_RETRY         3         extra attempts per write after SLVERR (0 = none)
//  DELAY_UNIT_CYCLES 100_000   clk_i cycles per delay tick (1 ms at 100 MHz)
// PORTS
//  clk_i        in   1               clock
//  rst_i        in   1               reset, asynchronous, active-high
//  start_i      in   1               pulse: run table from entry 0
//  busy_o       out  1               sequence in progress
//  done_o       out  1               sticky: END reached with no error
//  error_o      out  1               sticky: retries exhausted
//  err_idx_o    out  TBL_AW          index of failing entry
//  tbl_addr_o   out  TBL_AW          table read address
//  tbl_data_i   in   2+AW+DW         entry {cmd[1:0],addr,data}, valid 1 cycle after tbl_addr_o
//  axi4_lite_o  axi4_lite_if.master  to bridge; wstrb = all ones
// BEHAVIOUR
//  Reset: all outputs 0; awvalid/wvalid/arvalid/bready/rready 0; state IDLE.
//  cmd: 2'b00 WRITE addr<=data; 2'b01 DELAY data ticks; 2'b10 NOP; 2'b11 END.
//  FSM: IDLE -start_i-> FETCH (idx=0, clear done/error, busy=1) -1 cycle-> DECODE.
//   DECODE: WRITE->AXW; DELAY->WAIT (data==0: 0 ticks, straight to NEXT); NOP->NEXT; END->FIN.
//   AXW: awvalid & wvalid asserted in same cycle, held until handshake (bridge readies both together);
//        drop both the cycle after handshake -> BRESP with bready=1.
//   BRESP: on bvalid: OKAY -> NEXT; else retry_cnt<MAX_RETRY -> retry_cnt++, AXW; else ERR.
//   WAIT: prescaler counts DELAY_UNIT_CYCLES-1..0, tick counter counts data..1 -> NEXT.
//   NEXT: retry_cnt=0; idx==TBL_DEPTH-1 -> FIN (implicit END, no wrap); else idx++ -> FETCH.
//   FIN: busy=0, done_o=1 -> IDLE.  ERR: busy=0, error_o=1, err_idx_o=idx -> IDLE.
//  start_i ignored while busy_o=1; accepted in IDLE, restarts from 0 and clears done/error.
//  Latency: WRITE entry = 2 fetch cycles + AXI handshake + I2C transaction; NOP = 3 cycles.
//  Reset mid-operation: immediate return to IDLE, valids drop; bridge shares rst_i.
//  bvalid arriving outside BRESP: impossible by construction; bready only high in BRESP.
// CONFIGURATION
//  I2C_INIT_SEQ_VERIFY_EN defined: after OKAY write, RDBK state issues araddr=addr (arvalid until arready),
//   rready=1; rresp!=OKAY or rdata!=data counts as failure (same retry path from AXW).
//  Undefined: no read channel use; arvalid=0, rready=0 constant.
// STRUCTURE
//  Package i2c_init_seq_pkg: cmd enum (CMD_WRITE/DELAY/NOP/END), packed entry struct, state enum.
//  Sub-module i2c_seq_delay_timer: prescaler + tick down-counter, load/expired handshake.
// TESTING
//  T1 table {W 0x10<=0xA5, END}, bridge model OKAY -> one AW/W with awaddr=0x10, wdata=0xA5, wstrb=1; done_o=1, error_o=0.
//  T2 entry 2 SLVERR always, MAX_RETRY=3 -> exactly 4 AW handshakes on entry 2; error_o=1, err_idx_o=2, no entry 3 fetch.
//  T3 SLVERR once then OKAY -> 2 attempts, sequence completes, done_o=1.
//  T4 {DELAY 2, END}, DELAY_UNIT_CYCLES=10 -> busy_o high for 20 cycles + 5 overhead cycles; DELAY 0 adds 0 ticks.
//  T5 table without END, TBL_DEPTH=4 all NOP -> done_o after idx 3, tbl_addr_o never wraps to 0.
//  T6 rst_i asserted in AXW mid-handshake -> awvalid=0 same cycle; next start_i replays from entry 0.

Source files
------------

// File: rtl/i2c_init_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_init_seq_pkg
// Purpose  : Command, state and sizing definitions for the I2C init sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package i2c_init_seq_pkg;

   typedef enum logic [1:0] {
      CMD_WRITE = 2'b00,
      CMD_DELAY = 2'b01,
      CMD_NOP   = 2'b10,
      CMD_END   = 2'b11
   } cmd_e;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_FETCH   = 4'd1,
      ST_DECODE  = 4'd2,
      ST_AXW     = 4'd3,
      ST_BRESP   = 4'd4,
      ST_RDBK_AR = 4'd5,
      ST_RDBK_R  = 4'd6,
      ST_WAIT    = 4'd7,
      ST_NEXT    = 4'd8,
      ST_FIN     = 4'd9,
      ST_ERR     = 4'd10
   } state_e;

   localparam logic [1:0] c_resp_okay = 2'b00;

   // Counter width that never collapses to zero bits for degenerate sizes.
   function automatic int clog2_min1(input int value);
      return (value > 1) ? $clog2(value) : 1;
   endfunction

endpackage : i2c_init_seq_pkg
`default_nettype wire

// File: rtl/axi4_lite_if.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_if
// Purpose  : AXI4-Lite bundle between the init sequencer and the I2C bridge.
// Revision : 1.0 - initial release
// ============================================================================
interface axi4_lite_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface : axi4_lite_if
`default_nettype wire

// File: rtl/i2c_seq_delay_timer.sv
`default_nettype none
// ============================================================================
// Module   : i2c_seq_delay_timer
// Purpose  : Prescaler + tick down-counter; o_expired marks the final cycle.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_seq_delay_timer
   import i2c_init_seq_pkg::*;
#(
   parameter int CNT_WIDTH         = 8,
   parameter int DELAY_UNIT_CYCLES = 100_000
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 i_load,
   input  logic [CNT_WIDTH-1:0] i_ticks,
   output logic                 o_expired
);

   localparam int                   c_presc_w   = clog2_min1(DELAY_UNIT_CYCLES);
   localparam logic [c_presc_w-1:0] c_presc_max = c_presc_w'(DELAY_UNIT_CYCLES - 1);

   logic                 r_run;
   logic [c_presc_w-1:0] r_presc;
   logic [CNT_WIDTH-1:0] r_ticks;

   // Combinational so the owner leaves its wait state exactly ticks*unit cycles after load.
   assign o_expired = r_run && (r_presc == '0) && (r_ticks == CNT_WIDTH'(1));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_run   <= 1'b0;
         r_presc <= '0;
         r_ticks <= '0;
      end else if (i_load) begin
         r_run   <= (i_ticks != '0);
         r_presc <= c_presc_max;
         r_ticks <= i_ticks;
      end else if (r_run) begin
         if (r_presc == '0) begin
            r_presc <= c_presc_max;
            r_ticks <= r_ticks - CNT_WIDTH'(1);
            if (r_ticks == CNT_WIDTH'(1)) begin
               r_run <= 1'b0;
            end
         end else begin
            r_presc <= r_presc - c_presc_w'(1);
         end
      end
   end

endmodule : i2c_seq_delay_timer
`default_nettype wire

// File: rtl/axi4_lite_i2c_init_seq.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_i2c_init_seq
// Purpose  : Boot-time command-table walker issuing AXI4-Lite writes to the
//            I2C bridge, with delays, SLVERR retries and done/error report.
//            Optional read-back verify: define I2C_INIT_SEQ_VERIFY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_lite_i2c_init_seq
   import i2c_init_seq_pkg::*;
#(
   parameter int  DATA_WIDTH        = 8,
   parameter int  ADDR_WIDTH        = 8,
   parameter int  TBL_DEPTH         = 256,
   parameter int  MAX_RETRY         = 3,
   parameter int  DELAY_UNIT_CYCLES = 100_000,
   localparam int TBL_AW            = clog2_min1(TBL_DEPTH)
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                start_i,
   output logic                                busy_o,
   output logic                                done_o,
   output logic                                error_o,
   output logic [TBL_AW-1:0]                   err_idx_o,
   output logic [TBL_AW-1:0]                   tbl_addr_o,
   input  logic [2+ADDR_WIDTH+DATA_WIDTH-1:0]  tbl_data_i,
   axi4_lite_if.master                         axi4_lite_o
);

   localparam int c_retry_w = clog2_min1(MAX_RETRY + 1);

   typedef struct packed {
      cmd_e                  cmd;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } entry_t;

   state_e                r_state;
   state_e                w_next;
   entry_t                w_entry;
   logic [TBL_AW-1:0]     r_idx;
   logic [c_retry_w-1:0]  r_retry;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_done;
   logic                  r_error;
   logic [TBL_AW-1:0]     r_err_idx;
   logic                  w_last;
   logic                  w_can_retry;
   logic                  w_wr_ok;
   logic                  w_fail;
   logic                  w_tmr_load;
   logic                  w_tmr_expired;

   assign w_entry     = entry_t'(tbl_data_i);
   assign w_last      = (r_idx == TBL_AW'(TBL_DEPTH - 1));
   assign w_can_retry = (int'(r_retry) < MAX_RETRY);
   assign w_wr_ok     = axi4_lite_o.bvalid && (axi4_lite_o.bresp == c_resp_okay);
   assign w_tmr_load  = (r_state == ST_DECODE) && (w_entry.cmd == CMD_DELAY);

`ifdef I2C_INIT_SEQ_VERIFY_EN
   logic w_rd_ok;
   assign w_rd_ok = (axi4_lite_o.rresp == c_resp_okay) && (axi4_lite_o.rdata == r_data);
   // A bad read-back takes the same retry path as a write SLVERR.
   assign w_fail  = ((r_state == ST_BRESP) && axi4_lite_o.bvalid && !w_wr_ok) ||
                    ((r_state == ST_RDBK_R) && axi4_lite_o.rvalid && !w_rd_ok);
`else
   logic w_rd_unused;
   assign w_rd_unused = ^{axi4_lite_o.rdata, axi4_lite_o.rresp, axi4_lite_o.rvalid,
                          axi4_lite_o.arready};
   assign w_fail      = (r_state == ST_BRESP) && axi4_lite_o.bvalid && !w_wr_ok;
`endif

   i2c_seq_delay_timer #(
      .CNT_WIDTH         (DATA_WIDTH),
      .DELAY_UNIT_CYCLES (DELAY_UNIT_CYCLES)
   ) u_delay_timer (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .i_load    (w_tmr_load),
      .i_ticks   (w_entry.data),
      .o_expired (w_tmr_expired)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:   if (start_i) w_next = ST_FETCH;
         ST_FETCH:  w_next = ST_DECODE;
         ST_DECODE: begin
            case (w_entry.cmd)
               CMD_WRITE: w_next = ST_AXW;
               CMD_DELAY: w_next = (w_entry.data == '0) ? ST_NEXT : ST_WAIT;
               CMD_NOP:   w_next = ST_NEXT;
               default:   w_next = ST_FIN;
            endcase
         end
         ST_AXW:    if (axi4_lite_o.awready && axi4_lite_o.wready) w_next = ST_BRESP;
         ST_BRESP: begin
            if (w_fail) begin
               w_next = w_can_retry ? ST_AXW : ST_ERR;
            end else if (w_wr_ok) begin
`ifdef I2C_INIT_SEQ_VERIFY_EN
               w_next = ST_RDBK_AR;
`else
               w_next = ST_NEXT;
`endif
            end
         end
`ifdef I2C_INIT_SEQ_VERIFY_EN
         ST_RDBK_AR: if (axi4_lite_o.arready) w_next = ST_RDBK_R;
         ST_RDBK_R: begin
            if (w_fail) begin
               w_next = w_can_retry ? ST_AXW : ST_ERR;
            end else if (axi4_lite_o.rvalid) begin
               w_next = ST_NEXT;
            end
         end
`endif
         ST_WAIT:   if (w_tmr_expired) w_next = ST_NEXT;
         ST_NEXT:   w_next = w_last ? ST_FIN : ST_FETCH;
         ST_FIN:    w_next = ST_IDLE;
         ST_ERR:    w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   // Valids are decoded from the state register so an async reset drops them at once.
   always_comb begin
      busy_o              = 1'b0;
      axi4_lite_o.awvalid = 1'b0;
      axi4_lite_o.wvalid  = 1'b0;
      axi4_lite_o.bready  = 1'b0;
      axi4_lite_o.arvalid = 1'b0;
      axi4_lite_o.rready  = 1'b0;
      case (r_state)
         ST_FETCH, ST_DECODE, ST_WAIT, ST_NEXT: busy_o = 1'b1;
         ST_AXW: begin
            busy_o              = 1'b1;
            axi4_lite_o.awvalid = 1'b1;
            axi4_lite_o.wvalid  = 1'b1;
         end
         ST_BRESP: begin
            busy_o             = 1'b1;
            axi4_lite_o.bready = 1'b1;
         end
`ifdef I2C_INIT_SEQ_VERIFY_EN
         ST_RDBK_AR: begin
            busy_o              = 1'b1;
            axi4_lite_o.arvalid = 1'b1;
         end
         ST_RDBK_R: begin
            busy_o             = 1'b1;
            axi4_lite_o.rready = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_idx     <= '0;
         r_retry   <= '0;
         r_addr    <= '0;
         r_data    <= '0;
         r_done    <= 1'b0;
         r_error   <= 1'b0;
         r_err_idx <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start_i) begin
                  r_idx   <= '0;
                  r_retry <= '0;
                  r_done  <= 1'b0;
                  r_error <= 1'b0;
               end
            end
            ST_DECODE: begin
               r_addr <= w_entry.addr;
               r_data <= w_entry.data;
            end
            ST_NEXT: begin
               r_retry <= '0;
               if (!w_last) begin
                  r_idx <= r_idx + TBL_AW'(1);
               end
            end
            default: ;
         endcase
         if (w_fail && w_can_retry) begin
            r_retry <= r_retry + c_retry_w'(1);
         end
         // Sticky flags rise on entry so they are already visible in FIN/ERR.
         if ((w_next == ST_FIN) && (r_state != ST_FIN)) begin
            r_done <= 1'b1;
         end
         if ((w_next == ST_ERR) && (r_state != ST_ERR)) begin
            r_error   <= 1'b1;
            r_err_idx <= r_idx;
         end
      end
   end

   assign done_o             = r_done;
   assign error_o            = r_error;
   assign err_idx_o          = r_err_idx;
   assign tbl_addr_o         = r_idx;
   assign axi4_lite_o.awaddr = r_addr;
   assign axi4_lite_o.wdata  = r_data;
   assign axi4_lite_o.wstrb  = '1;
   assign axi4_lite_o.araddr = r_addr;

endmodule : axi4_lite_i2c_init_seq
`default_nettype wire

// File: tb/tb_axi4_lite_i2c_init_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_lite_i2c_init_seq
// Purpose  : Self-checking bench: sync table ROM, AXI4-Lite bridge model with
//            scripted SLVERR, and a table-walk reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_lite_i2c_init_seq;

   localparam int DW    = 8;
   localparam int AW    = 8;
   localparam int DEPTH = 4;
   localparam int MAXR  = 3;
   localparam int DU    = 10;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic          s;
   } wr_t;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          start_i = 1'b0;
   logic          busy_o, done_o, error_o;
   logic [1:0]    err_idx_o, tbl_addr_o;
   logic [17:0]   tbl_data;
   logic [17:0]   tbl_mem [DEPTH];

   axi4_lite_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

   axi4_lite_i2c_init_seq #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TBL_DEPTH(DEPTH),
      .MAX_RETRY(MAXR), .DELAY_UNIT_CYCLES(DU)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .busy_o(busy_o),
      .done_o(done_o), .error_o(error_o), .err_idx_o(err_idx_o),
      .tbl_addr_o(tbl_addr_o), .tbl_data_i(tbl_data), .axi4_lite_o(axi)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) tbl_data <= tbl_mem[tbl_addr_o];

   int         n_pass = 0;
   int         n_checks = 0;
   wr_t        wr_log[$];
   int         log_base = 0;
   int         fail_cfg [256];
   logic [7:0] regs [256];
   int         a_wait, b_wait, prior;
   bit         b_pend;

   // Bridge model: SLVERR for the first fail_cfg[addr] attempts of a run (-1: always).
   always @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         axi.awready <= 1'b0; axi.wready <= 1'b0; axi.bvalid <= 1'b0; axi.bresp <= 2'b00;
         axi.arready <= 1'b0; axi.rvalid <= 1'b0; axi.rdata <= '0; axi.rresp <= 2'b00;
         a_wait <= 0; b_wait <= 0; b_pend <= 1'b0;
      end else begin
         if (axi.awready && axi.awvalid && axi.wvalid) begin
            prior = 0;
            for (int k = log_base; k < wr_log.size(); k++)
               if (wr_log[k].a == axi.awaddr) prior++;
            wr_log.push_back('{a: axi.awaddr, d: axi.wdata, s: axi.wstrb});
            if (fail_cfg[axi.awaddr] < 0 || prior < fail_cfg[axi.awaddr]) begin
               axi.bresp <= 2'b10;
            end else begin
               axi.bresp <= 2'b00;
               regs[axi.awaddr] <= axi.wdata;
            end
            axi.awready <= 1'b0; axi.wready <= 1'b0;
            b_pend <= 1'b1; b_wait <= $urandom_range(0, 3);
         end else if (axi.awvalid && axi.wvalid && !axi.awready && !b_pend && !axi.bvalid) begin
            if (a_wait == 0) begin
               axi.awready <= 1'b1; axi.wready <= 1'b1; a_wait <= $urandom_range(0, 3);
            end else begin
               a_wait <= a_wait - 1;
            end
         end
         if (b_pend) begin
            if (b_wait == 0) begin axi.bvalid <= 1'b1; b_pend <= 1'b0; end
            else b_wait <= b_wait - 1;
         end else if (axi.bvalid && axi.bready) begin
            axi.bvalid <= 1'b0;
         end
         if (axi.arready && axi.arvalid) begin
            axi.arready <= 1'b0; axi.rvalid <= 1'b1;
            axi.rdata <= regs[axi.araddr]; axi.rresp <= 2'b00;
         end else if (axi.arvalid && !axi.arready && !axi.rvalid) begin
            axi.arready <= 1'b1;
         end
         if (axi.rvalid && axi.rready) axi.rvalid <= 1'b0;
      end
   end

   // Run observations and reference expectations.
   int  r_busy, r_maxa, r_wraps;
   bit  r_to;
   wr_t e_q[$];
   bit  e_done, e_err, e_timed;
   int  e_idx, e_max, e_busy;

   task automatic clear_cfg();
      for (int k = 0; k < 256; k++) fail_cfg[k] = 0;
   endtask

   task automatic run_seq();
      int prev;
      log_base = wr_log.size();
      @(negedge clk_i); start_i = 1'b1;
      @(negedge clk_i); start_i = 1'b0;
      r_busy = 0; r_maxa = 0; r_wraps = 0; r_to = 1'b1; prev = 0;
      for (int g = 0; g < 4000; g++) begin
         if (!busy_o) begin r_to = 1'b0; break; end
         r_busy++;
         if (int'(tbl_addr_o) > r_maxa) r_maxa = int'(tbl_addr_o);
         if (prev != 0 && tbl_addr_o == 2'd0) r_wraps++;
         prev = int'(tbl_addr_o);
         @(negedge clk_i);
      end
   endtask

   // Walks the table entry by entry: writes consume (fails+1) attempts, capped at MAXR+1.
   task automatic model();
      logic [1:0] cmd;
      logic [7:0] a, d;
      int f, n;
      e_q.delete(); e_done = 1'b1; e_err = 1'b0; e_idx = 0; e_max = 0; e_busy = 0; e_timed = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         cmd = tbl_mem[i][17:16]; a = tbl_mem[i][15:8]; d = tbl_mem[i][7:0];
         e_max = i;
         if (cmd == 2'b11) begin e_busy += 2; break; end
         if (cmd == 2'b01)      e_busy += 3 + DU * int'(d);
         else if (cmd == 2'b10) e_busy += 3;
         else begin
            e_timed = 1'b0;
            f = fail_cfg[a];
            n = (f < 0 || f > MAXR) ? MAXR + 1 : f + 1;
            repeat (n) e_q.push_back('{a: a, d: d, s: 1'b1});
            if (f < 0 || f > MAXR) begin e_err = 1'b1; e_done = 1'b0; e_idx = i; break; end
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk_i);
      n_checks++;
      if ({busy_o, done_o, error_o, err_idx_o, tbl_addr_o, axi.awvalid, axi.wvalid,
           axi.bready, axi.arvalid, axi.rready} !== 13'd0)
         $display("FAIL reset_in: outputs=%b want all 0", {busy_o, done_o, error_o, err_idx_o,
                  tbl_addr_o, axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready});
      else n_pass++;
      rst_i = 1'b0;
      repeat (2) @(negedge clk_i);
      n_checks++;
      if ({busy_o, done_o, error_o, tbl_addr_o, axi.awvalid, axi.bready} !== 7'd0)
         $display("FAIL reset_out: outputs=%b want 0", {busy_o, done_o, error_o, tbl_addr_o,
                  axi.awvalid, axi.bready});
      else n_pass++;
   endtask

   task automatic test_single_write();
      clear_cfg();
      tbl_mem[0] = {2'b00, 8'h10, 8'hA5}; tbl_mem[1] = {2'b11, 16'h0};
      run_seq();
      n_checks++; if (r_to) $display("FAIL t1_timeout: busy_o stuck high"); else n_pass++;
      n_checks++;
      if (wr_log.size() - log_base !== 1) $display("FAIL t1_count: got %0d want 1", wr_log.size() - log_base);
      else n_pass++;
      n_checks++;
      if (wr_log.size() <= log_base || wr_log[log_base] !== wr_t'({8'h10, 8'hA5, 1'b1}))
         $display("FAIL t1_beat: got %h want %h", (wr_log.size() > log_base) ? wr_log[log_base] : '0, {8'h10, 8'hA5, 1'b1});
      else n_pass++;
      n_checks++; if (done_o !== 1'b1) $display("FAIL t1_done: got %b want 1", done_o); else n_pass++;
      n_checks++; if (error_o !== 1'b0) $display("FAIL t1_error: got %b want 0", error_o); else n_pass++;
   endtask

   task automatic test_retry_exhaust();
      int hits;
      clear_cfg();
      tbl_mem[0] = {2'b00, 8'h20, 8'h11}; tbl_mem[1] = {2'b00, 8'h21, 8'h22};
      tbl_mem[2] = {2'b00, 8'h22, 8'h33}; tbl_mem[3] = {2'b00, 8'h23, 8'h44};
      fail_cfg[8'h22] = -1;
      run_seq();
      hits = 0;
      for (int k = log_base; k < wr_log.size(); k++) if (wr_log[k].a == 8'h22) hits++;
      n_checks++; if (r_to) $display("FAIL t2_timeout: busy_o stuck high"); else n_pass++;
      n_checks++; if (hits != 4) $display("FAIL t2_attempts: got %0d want 4", hits); else n_pass++;
      n_checks++;
      if (wr_log.size() - log_base != 6) $display("FAIL t2_total: got %0d want 6", wr_log.size() - log_base);
      else n_pass++;
      n_checks++;
      if ({error_o, done_o} !== 2'b10) $display("FAIL t2_flags: error/done=%b want 10", {error_o, done_o});
      else n_pass++;
      n_checks++; if (err_idx_o !== 2'd2) $display("FAIL t2_err_idx: got %0d want 2", err_idx_o); else n_pass++;
      n_checks++; if (r_maxa != 2) $display("FAIL t2_max_fetch: got %0d want 2", r_maxa); else n_pass++;
   endtask

   task automatic test_retry_once();
      clear_cfg();
      tbl_mem[0] = {2'b00, 8'h30, 8'h5A}; tbl_mem[1] = {2'b11, 16'h0};
      fail_cfg[8'h30] = 1;
      run_seq();
      n_checks++; if (r_to) $display("FAIL t3_timeout: busy_o stuck high"); else n_pass++;
      n_checks++;
      if (wr_log.size() - log_base != 2) $display("FAIL t3_attempts: got %0d want 2", wr_log.size() - log_base);
      else n_pass++;
      n_checks++;
      if (wr_log[wr_log.size() - 1] !== wr_t'({8'h30, 8'h5A, 1'b1}))
         $display("FAIL t3_beat: got %h want %h", wr_log[wr_log.size() - 1], {8'h30, 8'h5A, 1'b1});
      else n_pass++;
      n_checks++;
      if ({done_o, error_o} !== 2'b10) $display("FAIL t3_flags: done/error=%b want 10", {done_o, error_o});
      else n_pass++;
   endtask

   task automatic test_delay();
      clear_cfg();
      tbl_mem[0] = {2'b01, 8'h00, 8'd2}; tbl_mem[1] = {2'b11, 16'h0};
      run_seq();
      n_checks++; if (r_busy != 25 || r_to) $display("FAIL t4_delay2_busy: got %0d want 25", r_busy); else n_pass++;
      n_checks++; if (done_o !== 1'b1) $display("FAIL t4_delay2_done: got %b want 1", done_o); else n_pass++;
      tbl_mem[0] = {2'b01, 8'h00, 8'd0};
      run_seq();
      n_checks++; if (r_busy != 5 || r_to) $display("FAIL t4_delay0_busy: got %0d want 5", r_busy); else n_pass++;
      n_checks++; if (done_o !== 1'b1) $display("FAIL t4_delay0_done: got %b want 1", done_o); else n_pass++;
   endtask

   task automatic test_no_end();
      clear_cfg();
      for (int i = 0; i < DEPTH; i++) tbl_mem[i] = {2'b10, 16'h0};
      run_seq();
      n_checks++; if (r_busy != 12 || r_to) $display("FAIL t5_busy: got %0d want 12", r_busy); else n_pass++;
      n_checks++; if (done_o !== 1'b1) $display("FAIL t5_done: got %b want 1", done_o); else n_pass++;
      n_checks++; if (r_maxa != 3) $display("FAIL t5_max_fetch: got %0d want 3", r_maxa); else n_pass++;
      n_checks++; if (r_wraps != 0) $display("FAIL t5_wrap: got %0d want 0", r_wraps); else n_pass++;
      repeat (2) @(negedge clk_i);
      n_checks++; if (tbl_addr_o !== 2'd3) $display("FAIL t5_addr_hold: got %0d want 3", tbl_addr_o); else n_pass++;
   endtask

   task automatic test_reset_mid_write();
      bit seen;
      clear_cfg();
      tbl_mem[0] = {2'b00, 8'h40, 8'h77}; tbl_mem[1] = {2'b00, 8'h41, 8'h88}; tbl_mem[2] = {2'b11, 16'h0};
      @(negedge clk_i); start_i = 1'b1;
      @(negedge clk_i); start_i = 1'b0;
      seen = 1'b0;
      for (int g = 0; g < 100; g++) begin
         if (axi.awvalid && axi.awready) begin seen = 1'b1; break; end
         @(negedge clk_i);
      end
      n_checks++; if (!seen) $display("FAIL t6_no_handshake: awvalid&awready never seen"); else n_pass++;
      #1 rst_i = 1'b1;
      #1;
      n_checks++;
      if ({axi.awvalid, axi.wvalid, busy_o} !== 3'b000)
         $display("FAIL t6_valid_drop: awvalid/wvalid/busy=%b want 000", {axi.awvalid, axi.wvalid, busy_o});
      else n_pass++;
      @(negedge clk_i); rst_i = 1'b0;
      run_seq();
      n_checks++; if (r_to) $display("FAIL t6_timeout: busy_o stuck high"); else n_pass++;
      n_checks++;
      if (wr_log.size() - log_base != 2 || wr_log[log_base].a !== 8'h40)
         $display("FAIL t6_replay: count=%0d first=%h want 2 and 40", wr_log.size() - log_base,
                  (wr_log.size() > log_base) ? wr_log[log_base].a : 8'h00);
      else n_pass++;
      n_checks++; if (done_o !== 1'b1) $display("FAIL t6_done: got %b want 1", done_o); else n_pass++;
   endtask

   task automatic test_random();
      int r;
      logic [7:0] a;
      for (int it = 0; it < 40; it++) begin
         clear_cfg();
         for (int i = 0; i < DEPTH; i++) begin
            r = $urandom_range(0, 9);
            a = 8'(($urandom_range(0, 63) << 2) | i);
            if (r <= 4) begin
               tbl_mem[i] = {2'b00, a, 8'($urandom_range(0, 255))};
               r = $urandom_range(0, 9);
               fail_cfg[a] = (r <= 5) ? 0 : (r == 9) ? -1 : r - 5;
            end else if (r <= 6) tbl_mem[i] = {2'b01, a, 8'($urandom_range(0, 3))};
            else if (r <= 8)     tbl_mem[i] = {2'b10, a, 8'h00};
            else                 tbl_mem[i] = {2'b11, a, 8'h00};
         end
         model();
         run_seq();
         n_checks++; if (r_to) $display("FAIL rnd%0d_timeout: busy_o stuck high", it); else n_pass++;
         n_checks++;
         if ({done_o, error_o} !== {e_done, e_err})
            $display("FAIL rnd%0d_flags: done/error=%b want %b", it, {done_o, error_o}, {e_done, e_err});
         else n_pass++;
         if (e_err) begin
            n_checks++;
            if (int'(err_idx_o) != e_idx) $display("FAIL rnd%0d_err_idx: got %0d want %0d", it, err_idx_o, e_idx);
            else n_pass++;
         end
         n_checks++;
         if (wr_log.size() - log_base != e_q.size())
            $display("FAIL rnd%0d_count: got %0d want %0d", it, wr_log.size() - log_base, e_q.size());
         else n_pass++;
         for (int k = 0; k < e_q.size() && log_base + k < wr_log.size(); k++) begin
            n_checks++;
            if (wr_log[log_base + k] !== e_q[k])
               $display("FAIL rnd%0d_beat%0d: got %h want %h", it, k, wr_log[log_base + k], e_q[k]);
            else n_pass++;
         end
         n_checks++;
         if (r_maxa != e_max) $display("FAIL rnd%0d_max_fetch: got %0d want %0d", it, r_maxa, e_max);
         else n_pass++;
         if (e_timed) begin
            n_checks++;
            if (r_busy != e_busy) $display("FAIL rnd%0d_busy: got %0d want %0d", it, r_busy, e_busy);
            else n_pass++;
         end
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) tbl_mem[i] = {2'b11, 16'h0};
      clear_cfg();
      test_reset();
      test_single_write();
      test_retry_exhaust();
      test_retry_once();
      test_delay();
      test_no_end();
      test_reset_mid_write();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_axi4_lite_i2c_init_seq
`default_nettype wire
